// File: rtl/stp_trigger_conditioner.sv
// stp_trigger_conditioner: masked compare trigger (level/edge, Nth occurrence) with delay-matched acquisition outputs; optional auto re-arm via STP_TRIG_AUTOREARM_EN
module stp_trigger_conditioner #(
    parameter int DATA_BITS   = 32,
    parameter int CNT_BITS    = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 acq_clk,
    input  logic                 clr,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [DATA_BITS-1:0] cfg_value,
    input  logic [DATA_BITS-1:0] cfg_mask,
    input  logic                 cfg_edge,
    input  logic [CNT_BITS-1:0]  cfg_occurrences,
`ifdef STP_TRIG_AUTOREARM_EN
    input  logic [CNT_BITS-1:0]  cfg_holdoff,
`endif
    input  logic [DATA_BITS-1:0] probe_in,
    input  logic                 probe_valid,
    output logic [DATA_BITS-1:0] acq_data_out,
    output logic                 acq_trigger_out,
    output logic                 acq_storage_qualifier_out,
    output logic [1:0]           state_out,
    output logic [CNT_BITS-1:0]  hit_count
);
    typedef enum logic [1:0] {IDLE, ARMED, FIRED, DONE} state_t;
    state_t                 state;
    logic [DATA_BITS-1:0]   value_q, mask_q;
    logic                   edge_q, m_prev;
    logic [CNT_BITS-1:0]    occ_q, occ_eff;
    logic [CNT_BITS:0]      cnt_inc;
    logic                   match, hit, fire, qual;
    logic [DATA_BITS-1:0]   data_p [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] trig_p, qual_p;
`ifdef STP_TRIG_AUTOREARM_EN
    logic [CNT_BITS-1:0]    holdoff_q, hold_cnt;
    logic [CNT_BITS:0]      hold_inc;
    assign hold_inc = {1'b0, hold_cnt} + (CNT_BITS+1)'(1);
`endif
    assign match   = ((probe_in ^ value_q) & mask_q) == '0;
    assign hit     = probe_valid & match & ~(edge_q & m_prev);
    assign occ_eff = (occ_q == '0) ? CNT_BITS'(1) : occ_q;
    assign cnt_inc = {1'b0, hit_count} + (CNT_BITS+1)'(1);
    // a hit is discarded when arm or disarm lands on the same cycle
    assign fire    = (state == ARMED) & hit & ~arm & ~disarm & (cnt_inc >= {1'b0, occ_eff});
    assign qual    = probe_valid & (state == ARMED);
    assign state_out                 = state;
    assign acq_data_out              = data_p[PIPE_STAGES-1];
    assign acq_trigger_out           = trig_p[PIPE_STAGES-1];
    assign acq_storage_qualifier_out = qual_p[PIPE_STAGES-1];
    // trigger FSM, occurrence counter, match history and latched configuration
    always_ff @(posedge acq_clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            hit_count <= '0;
            m_prev    <= 1'b0;
            value_q   <= '0;
            mask_q    <= '0;
            edge_q    <= 1'b0;
            occ_q     <= '0;
`ifdef STP_TRIG_AUTOREARM_EN
            holdoff_q <= '0;
            hold_cnt  <= '0;
`endif
        end else begin
            if (probe_valid) m_prev <= match;
            if (disarm) state <= IDLE;
            else if (arm) begin
                state     <= ARMED;
                hit_count <= '0;
                m_prev    <= 1'b0;
                value_q   <= cfg_value;
                mask_q    <= cfg_mask;
                edge_q    <= cfg_edge;
                occ_q     <= cfg_occurrences;
`ifdef STP_TRIG_AUTOREARM_EN
                holdoff_q <= cfg_holdoff;
`endif
            end else begin
                case (state)
                    ARMED: if (hit) begin
                        hit_count <= cnt_inc[CNT_BITS] ? hit_count : cnt_inc[CNT_BITS-1:0];
                        if (fire) state <= FIRED;
                    end
                    FIRED: begin
                        state <= DONE;
`ifdef STP_TRIG_AUTOREARM_EN
                        hold_cnt <= '0;
`endif
                    end
                    DONE: begin
`ifdef STP_TRIG_AUTOREARM_EN
                        if (hold_inc >= {1'b0, holdoff_q}) begin
                            state     <= ARMED;
                            hit_count <= '0;
                            m_prev    <= 1'b0;
                        end else hold_cnt <= hold_inc[CNT_BITS-1:0];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
    // delay line keeping data, trigger and qualifier cycle-aligned
    always_ff @(posedge acq_clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < PIPE_STAGES; i++) data_p[i] <= '0;
            trig_p <= '0;
            qual_p <= '0;
        end else begin
            data_p[0] <= probe_in;
            for (int i = 1; i < PIPE_STAGES; i++) data_p[i] <= data_p[i-1];
            trig_p <= (trig_p << 1) | PIPE_STAGES'(fire);
            qual_p <= (qual_p << 1) | PIPE_STAGES'(qual);
        end
    end
endmodule

// File: tb/tb_stp_trigger_conditioner.sv
// tb_stp_trigger_conditioner: directed stimulus against a cycle-level behavioural model of the trigger conditioner
module tb_stp_trigger_conditioner;
    localparam int P = 2;
`ifdef STP_TRIG_AUTOREARM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    logic       acq_clk = 1'b0, clr = 1'b1, arm = 1'b0, disarm = 1'b0, cfg_edge = 1'b0, probe_valid = 1'b0;
    logic [7:0] cfg_value = '0, cfg_mask = '0, cfg_occurrences = '0, cfg_holdoff = '0, probe_in = '0;
    logic [7:0] acq_data_out, hit_count;
    logic       acq_trigger_out, acq_storage_qualifier_out;
    logic [1:0] state_out;
    int total = 0, bad = 0, trig_seen = 0;

    always #5 acq_clk = ~acq_clk;

    stp_trigger_conditioner #(.DATA_BITS(8), .CNT_BITS(8), .PIPE_STAGES(P)) dut (
        .acq_clk(acq_clk), .clr(clr), .arm(arm), .disarm(disarm),
        .cfg_value(cfg_value), .cfg_mask(cfg_mask), .cfg_edge(cfg_edge), .cfg_occurrences(cfg_occurrences),
`ifdef STP_TRIG_AUTOREARM_EN
        .cfg_holdoff(cfg_holdoff),
`endif
        .probe_in(probe_in), .probe_valid(probe_valid),
        .acq_data_out(acq_data_out), .acq_trigger_out(acq_trigger_out),
        .acq_storage_qualifier_out(acq_storage_qualifier_out),
        .state_out(state_out), .hit_count(hit_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // model: st is 0 idle, 1 armed, 2 fired, 3 done; pipeline is a queue of recorded samples
    typedef struct {logic [7:0] d; bit t; bit q;} ent_t;
    ent_t pq[$];
    int st = 0, hits = 0, cyc = 0, done_at = 0;
    bit prev = 0, c_edge = 0, e_trig = 0, e_qual = 0;
    logic [7:0] c_val = '0, c_mask = '0, c_occ = '0, c_hold = '0, e_data = '0;

    always @(posedge acq_clk or posedge clr) begin : model
        bit m, h, t, q;
        ent_t e;
        if (clr) begin
            st = 0; hits = 0; prev = 0; c_edge = 0;
            c_val = '0; c_mask = '0; c_occ = '0; c_hold = '0;
            pq.delete();
            e_data = '0; e_trig = 0; e_qual = 0;
        end else begin
            cyc++;
            m = ((probe_in ^ c_val) & c_mask) == 8'h00;
            h = probe_valid && m && !(c_edge && prev);
            q = probe_valid && st == 1;
            t = 0;
            if (probe_valid) prev = m;
            if (disarm) st = 0;
            else if (arm) begin
                st = 1; hits = 0; prev = 0;
                c_val = cfg_value; c_mask = cfg_mask; c_edge = cfg_edge;
                c_occ = cfg_occurrences; c_hold = cfg_holdoff;
            end else if (st == 1 && h) begin
                if (hits < 255) hits++;
                if (hits >= ((c_occ == 0) ? 1 : int'(c_occ))) begin t = 1; st = 2; end
            end else if (st == 2) begin
                st = 3; done_at = cyc;
            end else if (st == 3 && AUTO && cyc - done_at >= ((c_hold == 0) ? 1 : int'(c_hold))) begin
                st = 1; hits = 0; prev = 0;
            end
            e.d = probe_in; e.t = t; e.q = q;
            pq.push_back(e);
            if (pq.size() == P) begin
                e = pq.pop_front();
                e_data = e.d; e_trig = e.t; e_qual = e.q;
            end
        end
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge acq_clk) begin
        if (!clr) begin
            check("state", state_out, st);
            check("hit_count", hit_count, hits);
            check("data", acq_data_out, e_data);
            check("trigger", acq_trigger_out, e_trig);
            check("qualifier", acq_storage_qualifier_out, e_qual);
            if (acq_trigger_out) trig_seen++;
        end
    end

    task automatic cfg(input logic [7:0] v, input logic [7:0] mk, input bit e, input logic [7:0] o, input logic [7:0] h);
        cfg_value = v; cfg_mask = mk; cfg_edge = e; cfg_occurrences = o; cfg_holdoff = h;
    endtask

    task automatic drive(input bit a, input bit d, input logic [7:0] pd, input bit pv);
        arm = a; disarm = d; probe_in = pd; probe_valid = pv;
        @(posedge acq_clk);
        #1;
        arm = 0; disarm = 0;
    endtask

    initial begin
        #1;
        check("rst_state", state_out, 0);
        check("rst_data", acq_data_out, 0);
        check("rst_trig", acq_trigger_out, 0);
        check("rst_qual", acq_storage_qualifier_out, 0);
        check("rst_cnt", hit_count, 0);
        #11 clr = 0;
        @(posedge acq_clk); #1;

        // level trigger, single occurrence
        cfg(8'h5A, 8'hFF, 0, 8'd1, 8'd0);
        drive(1, 0, 8'h00, 0);
        check("lvl_armed", state_out, 1);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h5A, 1);
        check("lvl_fired", state_out, 2);
        check("lvl_cnt", hit_count, 1);
        drive(0, 0, 8'h5A, 1);
        check("lvl_done", state_out, 3);
        check("lvl_trig", acq_trigger_out, 1);
        check("lvl_data", acq_data_out, 8'h5A);
        check("model_pin_lvl", e_trig, 1);
        drive(0, 0, 8'h00, 0);
        check("lvl_pulse", acq_trigger_out, 0);
        check("lvl_post_qual", acq_storage_qualifier_out, 0);
        repeat (4) drive(0, 0, 8'h00, 0);
        check("lvl_once", trig_seen, 1);

        // edge mode, third occurrence, with invalid gaps in the second run
        cfg(8'h3C, 8'hFF, 1, 8'd3, 8'd0);
        drive(1, 0, 8'h00, 0);
        repeat (4) drive(0, 0, 8'h3C, 1);
        check("edge_run1", hit_count, 1);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h3C, 1);
        drive(0, 0, 8'h3C, 0);
        drive(0, 0, 8'h3C, 1);
        check("gap_qual", acq_storage_qualifier_out, 0);
        drive(0, 0, 8'h3C, 0);
        drive(0, 0, 8'h3C, 1);
        check("gap_cnt", hit_count, 2);
        drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h3C, 1);
        check("edge_fired", state_out, 2);
        check("edge_cnt", hit_count, 3);
        check("model_pin_edge", hits, 3);
        drive(0, 0, 8'h3C, 1);
        check("edge_trig", acq_trigger_out, 1);
        check("edge_data", acq_data_out, 8'h3C);
        repeat (3) drive(0, 0, 8'h00, 0);
        check("edge_once", trig_seen, 2);
        check("edge_hold_cnt", hit_count, 3);

        // disarm priority over arm and over a coincident hit
        cfg(8'h11, 8'hFF, 0, 8'd2, 8'd0);
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h11, 1);
        drive(1, 1, 8'h00, 0);
        check("prio_state", state_out, 0);
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h11, 1);
        drive(0, 1, 8'h11, 1);
        check("prio_idle", state_out, 0);
        check("prio_cnt", hit_count, 1);
        repeat (4) drive(0, 0, 8'h00, 0);
        check("prio_notrig", trig_seen, 2);

        // zero occurrences and zero mask fire on the first valid sample
        cfg(8'hA5, 8'h00, 0, 8'd0, 8'd5);
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h77, 1);
        check("occ0_fired", state_out, 2);
        drive(0, 0, 8'h00, 0);
        check("occ0_trig", acq_trigger_out, 1);
        check("occ0_data", acq_data_out, 8'h77);
        check("occ0_done", state_out, 3);
        begin
            int n;
            n = 0;
            while (state_out != 2'd1 && n < 20) begin
                drive(0, 0, 8'h00, 0);
                n++;
            end
`ifdef STP_TRIG_AUTOREARM_EN
            check("rearm_delay", n, 5);
            drive(0, 0, 8'h99, 1);
            check("rearm_fired", state_out, 2);
            repeat (3) drive(0, 0, 8'h00, 0);
            check("rearm_trig2", trig_seen, 4);
`else
            check("no_rearm", state_out, 3);
            check("occ0_once", trig_seen, 3);
`endif
        end

        // asynchronous reset mid-stream while armed
        cfg(8'h5A, 8'hFF, 0, 8'd5, 8'd0);
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h5A, 1);
        drive(0, 0, 8'h5A, 1);
        drive(0, 0, 8'h00, 1);
        check("pre_rst_cnt", hit_count, 2);
        check("pre_rst_qual", acq_storage_qualifier_out, 1);
        #2 clr = 1;
        #1;
        check("arst_state", state_out, 0);
        check("arst_cnt", hit_count, 0);
        check("arst_data", acq_data_out, 0);
        check("arst_trig", acq_trigger_out, 0);
        check("arst_qual", acq_storage_qualifier_out, 0);
        @(negedge acq_clk);
        clr = 0;
        @(posedge acq_clk); #1;
        repeat (3) drive(0, 0, 8'h5A, 1);
        check("post_rst_idle", state_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stp_trigger_conditioner.md
Name: stp_trigger_conditioner

Overview:
Acquisition front end that sits directly upstream of the logic-analyzer node. It registers raw probe signals and evaluates a masked compare trigger with level/edge mode and an Nth-occurrence counter. It drives the node's acq_data_in, acq_trigger_in and acq_storage_qualifier_in, with data and trigger cycle-aligned. Used in the verilated simulation library to give the capture path real trigger behaviour.

Parameters:
DATA_BITS, 32, probe/data width
CNT_BITS, 8, occurrence counter width
PIPE_STAGES, 2, probe_in to output latency in cycles (legal range 1..4)

Ports:
acq_clk  in  1  acquisition clock, all logic on rising edge
clr  in  1  asynchronous active-high reset
arm  in  1  one-cycle pulse; latch config, clear counters, enter ARMED
disarm  in  1  one-cycle pulse; return to IDLE
cfg_value  in  DATA_BITS  compare value
cfg_mask  in  DATA_BITS  compare mask; 1 = bit participates
cfg_edge  in  1  0 = level match, 1 = rising edge of match
cfg_occurrences  in  CNT_BITS  hits required to fire; 0 treated as 1
probe_in  in  DATA_BITS  raw probe sample
probe_valid  in  1  probe_in is a sample this cycle
acq_data_out  out  DATA_BITS  delayed probe data to analyzer acq_data_in
acq_trigger_out  out  1  one-cycle trigger to analyzer acq_trigger_in
acq_storage_qualifier_out  out  1  store-this-sample to analyzer
state_out  out  2  FSM state: IDLE=0, ARMED=1, FIRED=2, DONE=3
hit_count  out  CNT_BITS  hits counted since last arm, saturating

Behaviour:
- Reset (clr high, async): state IDLE; all pipeline registers, acq_data_out, acq_trigger_out, acq_storage_qualifier_out, hit_count, latched config and match history are 0. Deassertion is synchronised to acq_clk by the integrator.
- Config latched on the arm cycle. Changes to cfg_* while not arming are ignored.
- Match: m = (((probe_in ^ value) & mask) == 0), evaluated only when probe_valid. A zero mask always matches.
- Hit: level mode hit = valid & m. Edge mode hit = valid & m & ~m_prev. m_prev updates only on valid cycles and is cleared on arm, so a match on the first valid sample after arm counts as an edge.
- FSM:
  - IDLE: go to ARMED on arm.
  - ARMED: on a hit, hit_count increments. If the incremented count is >= the effective occurrences, the sample is the trigger sample and the state moves to FIRED.
  - FIRED: lasts exactly one cycle, then DONE.
  - DONE: holds; arm goes to ARMED.
- disarm forces IDLE from any state and wins over a simultaneous arm. A simultaneous hit is discarded.
- arm while ARMED, FIRED or DONE restarts: hit_count = 0, m_prev = 0, config relatched.
- hit_count saturates at 2^CNT_BITS-1 and holds its value in FIRED and DONE.
- Pipeline: probe_in, probe_valid, the trigger-sample flag and the qualifier flag pass through PIPE_STAGES registers.
  - acq_data_out = probe_in from PIPE_STAGES cycles earlier.
  - acq_trigger_out is high for exactly one cycle, coincident with the trigger sample on acq_data_out.
  - acq_storage_qualifier_out = delayed (probe_valid & state in ARMED at sample time). The trigger sample is qualified; post-trigger samples are not.
- The pipeline keeps draining after disarm. A trigger already in flight still emerges.
- At most one trigger per arm.

Optional Feature:
STP_TRIG_AUTOREARM_EN
- Defined: adds input cfg_holdoff[CNT_BITS], latched on arm. The DONE state counts cfg_holdoff cycles, then returns to ARMED with hit_count and m_prev cleared. Holdoff 0 re-arms on the cycle after DONE is entered. disarm still forces IDLE.
- Undefined: no cfg_holdoff port, and DONE holds until arm or disarm.

Test Plan:
- Reset: assert clr mid-stream with state ARMED -> state_out=0 and all outputs 0 immediately, with no clock edge needed.
- Level trigger: mask=0xFF, value=0x5A, occurrences=1, PIPE_STAGES=2, arm, then stream valid 0x00,0x5A,0x5A -> acq_trigger_out high exactly 2 cycles after 0x5A enters, with acq_data_out=0x5A. Single pulse only; state_out goes 1->2->3.
- Edge plus count: edge=1, occurrences=3, stream a match held for 4 valid cycles, drop, repeat twice -> trigger on the first sample of the 3rd match run; hit_count=3.
- Gaps: insert probe_valid=0 cycles inside a match run in edge mode -> no extra hits counted; acq_storage_qualifier_out low on the invalid slots.
- Priority: arm and disarm in the same cycle while ARMED -> state IDLE. A hit coinciding with disarm -> hit_count unchanged, no trigger.
- Occurrences=0 and mask=0: arm, then one valid sample -> trigger on that sample. With STP_TRIG_AUTOREARM_EN and holdoff=5 -> back in ARMED exactly 5 cycles after DONE is entered, and a second trigger fires.
